// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: iterative shift-add multiplier / restoring divider for EX; define MULDIV_EARLY_OUT_EN for multiply early-out
module ex_muldiv_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sign,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic neg_q, neg_d, nrem_q, nrem_d, div_zero_q, div_zero_d;
  logic [WIDTH-1:0] a_q, a_d, result_q, result_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic a_neg, b_neg, finish, accept, dz_start;
  logic [WIDTH-1:0] mag_a, mag_b, fin_res;
  logic [WIDTH:0] sum, trial, diff;
  logic [2*WIDTH-1:0] mul_nx, div_nx, step, fin_acc, prod;
  // operand conditioning, one iteration step and final sign correction
  always_comb begin
    a_neg = sign & op_a[WIDTH-1];
    b_neg = sign & op_b[WIDTH-1];
    mag_a = a_neg ? -op_a : op_a;
    mag_b = b_neg ? -op_b : op_b;
    accept = ~flush & (state_q == IDLE) & start;
    dz_start = op[1] & (op_b == '0);
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_nx = {sum, acc_q[WIDTH-1:1]};
    trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff = trial - {1'b0, a_q};
    div_nx = diff[WIDTH] ? {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                         : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    step = op_q[1] ? div_nx : mul_nx;
`ifdef MULDIV_EARLY_OUT_EN
    finish = (cnt_q == LAST) | (~op_q[1] & ~|(mul_nx[WIDTH-1:0] & ({WIDTH{1'b1}} >> (cnt_q + 1'b1))));
    fin_acc = op_q[1] ? step : mul_nx >> (LAST - cnt_q);
`else
    finish = cnt_q == LAST;
    fin_acc = step;
`endif
    prod = neg_q ? -fin_acc : fin_acc;
    fin_res = ~op_q[1] ? (op_q[0] ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0])
            : op_q[0] ? (nrem_q ? -fin_acc[2*WIDTH-1:WIDTH] : fin_acc[2*WIDTH-1:WIDTH])
            : (neg_q ? -fin_acc[WIDTH-1:0] : fin_acc[WIDTH-1:0]);
  end
  // next state: flush beats start and completion
  always_comb begin
    state_d = flush ? IDLE
            : state_q == IDLE ? (start ? (dz_start ? DONE : CALC) : IDLE)
            : state_q == CALC ? (finish ? DONE : CALC)
            : IDLE;
  end
  // datapath register updates: capture on accept, iterate in CALC, load result on completion
  always_comb begin
    cnt_d = cnt_q;
    op_d = op_q;
    neg_d = neg_q;
    nrem_d = nrem_q;
    a_d = a_q;
    acc_d = acc_q;
    result_d = result_q;
    div_zero_d = div_zero_q;
    if (accept) begin
      cnt_d = '0;
      op_d = op;
      neg_d = a_neg ^ b_neg;
      nrem_d = a_neg;
      a_d = op[1] ? mag_b : mag_a;
      acc_d = {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
      result_d = dz_start ? (op[0] ? op_a : '1) : result_q;
      div_zero_d = dz_start ? 1'b1 : div_zero_q;
    end else if (~flush & (state_q == CALC)) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = step;
      result_d = finish ? fin_res : result_q;
      div_zero_d = finish ? 1'b0 : div_zero_q;
    end
  end
  // outputs: a flushed DONE cycle does not count as completion
  always_comb begin
    busy = state_q == CALC;
    done = (state_q == DONE) & ~flush;
    result = result_q;
    div_zero = div_zero_q;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      op_q <= '0;
      neg_q <= 1'b0;
      nrem_q <= 1'b0;
      a_q <= '0;
      acc_q <= '0;
      result_q <= '0;
      div_zero_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      op_q <= op_d;
      neg_q <= neg_d;
      nrem_q <= nrem_d;
      a_q <= a_d;
      acc_q <= acc_d;
      result_q <= result_d;
      div_zero_q <= div_zero_d;
    end
  end
endmodule

// File: tb/tb_ex_muldiv_iter.sv
// tb_ex_muldiv_iter: randomized and directed checks of ex_muldiv_iter against an arithmetic reference model
module tb_ex_muldiv_iter;
  localparam int W = 16;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, sign = 1'b0, flush = 1'b0;
  logic [1:0] op = 2'b00;
  logic [W-1:0] op_a = '0, op_b = '0, result;
  logic busy, done, div_zero;
  logic [W-1:0] last_res = '0;
  int n_tests = 0, n_fail = 0;

  ex_muldiv_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sign(sign),
    .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy), .done(done),
    .result(result), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {div_zero, result} from plain integer arithmetic
  function automatic logic [W:0] model(input logic [1:0] o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, r;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    if (o[1] && b == '0) return {1'b1, o[0] ? a : {W{1'b1}}};
    if (!o[1]) begin
      r = sa * sb;
      return {1'b0, o[0] ? W'(r >>> W) : W'(r)};
    end
    r = o[0] ? sa % sb : sa / sb;
    return {1'b0, W'(r)};
  endfunction

  // cycles from the start cycle to the done cycle
  function automatic int lat(input logic [1:0] o, input logic s, input logic [W-1:0] b);
    logic [W-1:0] m;
    int steps;
    if (o[1]) return (b == '0) ? 1 : W + 1;
    m = (s && b[W-1]) ? -b : b;
    steps = 1;
    for (int i = 0; i < W; i++) if (m[i]) steps = i + 1;
    return EARLY ? steps + 1 : W + 1;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] exp;
    int l, n, nb;
    bit seen;
    exp = model(o, s, a, b);
    l = lat(o, s, b);
    @(negedge clk);
    op = o; sign = s; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; op = 2'($urandom); sign = 1'($urandom); op_a = W'($urandom); op_b = W'($urandom);
    n = 0; nb = 0; seen = 1'b0;
    while (!seen && n < 3 * W) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else if (busy) nb++;
    end
    check({tag, "_lat"}, seen ? n : 0, l);
    check({tag, "_res"}, result, exp[W-1:0]);
    check({tag, "_dz"}, div_zero, exp[W]);
    check({tag, "_busycyc"}, nb, l - 1);
    check({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    last_res = exp[W-1:0];
  endtask

  initial begin
    int nd;
    logic [1:0] o;
    logic [W-1:0] a, b;
    #2 rst_n = 1'b0;
    #1 check("reset_out", {busy, done, div_zero, result}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("mul_s", 2'b00, 1'b1, 16'h0007, 16'hFFFD);
    run_op("mulh_u", 2'b01, 1'b0, 16'hFFFF, 16'hFFFF);
    run_op("mul_u", 2'b00, 1'b0, 16'hFFFF, 16'hFFFF);
    run_op("mulh_min", 2'b01, 1'b1, 16'h8000, 16'h8000);
    run_op("div_s", 2'b10, 1'b1, 16'hFFF9, 16'h0002);
    run_op("rem_s", 2'b11, 1'b1, 16'hFFF9, 16'h0002);
    run_op("div_min", 2'b10, 1'b1, 16'h8000, 16'hFFFF);
    run_op("rem_min", 2'b11, 1'b1, 16'h8000, 16'hFFFF);
    run_op("div_z", 2'b10, 1'b1, 16'h1234, 16'h0000);
    run_op("rem_z", 2'b11, 1'b0, 16'h1234, 16'h0000);
    run_op("mul_early", 2'b00, 1'b0, 16'h1234, 16'h0003);
    run_op("mul_one", 2'b00, 1'b1, 16'hABCD, 16'h0001);
    run_op("div_u", 2'b10, 1'b0, 16'hFFF9, 16'h0002);
    // flush mid-divide
    @(negedge clk);
    op = 2'b10; sign = 1'b0; op_a = 16'h1234; op_b = 16'h0007; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_res", result, last_res);
    nd = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("flush_nodone", nd, 0);
    // start with flush in IDLE is dropped
    @(negedge clk);
    op = 2'b00; op_a = 16'h0005; op_b = 16'h0005; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("startflush_busy", busy, 0);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("startflush_nodone", nd, 0);
    check("startflush_res", result, last_res);
    // asynchronous reset mid-operation
    run_op("pre_rst", 2'b10, 1'b0, 16'h0100, 16'h0000);
    @(negedge clk);
    op = 2'b00; sign = 1'b0; op_a = 16'h1234; op_b = 16'h8765; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midrst_out", {busy, done, div_zero, result}, 0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("midrst_nodone", nd, 0);
    last_res = '0;
    // randomized operations
    for (int i = 0; i < 150; i++) begin
      o = 2'($urandom_range(0, 3));
      a = W'($urandom);
      b = W'($urandom);
      case ($urandom_range(0, 15))
        0, 1: b = '0;
        2: begin a = 16'h8000; b = 16'hFFFF; end
        3, 4: b = W'($urandom_range(0, 3));
        5: b = 16'hFFFF;
        default: ;
      endcase
      run_op("rand", o, 1'($urandom), a, b);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
